issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 53 +++++
 rtl/issue_ctrl_decoder.sv | 120 ++++++++++++
 rtl/issue_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared configuration for the issue controller.
// Holds the instruction/register/immediate types, the decoded-operation
// enum, the RV32I base opcode constants, the controller FSM states, the
// decoder result struct and the default instruction-queue depth.
package issue_ctrl_pkg;

    localparam int QUEUE_DEPTH_DEF = 4;

    typedef logic [31:0] inst_t;
    typedef logic [4:0]  reg_id_t;
    typedef logic [31:0] imm_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // OP_NOP (0) is the reset value of the payload and the fallback for an
    // unassigned funct3 inside a legal opcode.
    typedef enum logic [5:0] {
        OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_WAIT_BR = 1'b1
    } st_e;

    typedef struct packed {
        op_e     op;
        reg_id_t rd;
        reg_id_t rs1;
        reg_id_t rs2;
        imm_t    imm;
        logic    is_ls;
        logic    is_store;
        logic    is_br;
        logic    illegal;
    } dec_t;

endpackage

// File: rtl/issue_ctrl_decoder.sv
// Combinational RV32I decoder for the head of the issue queue.
//   inst_i : raw 32-bit instruction word
//   dec_o  : operation, register ids, sign-extended immediate and class
//            flags (load/store, store, branch/jump, illegal opcode)
// Register ids that the format does not carry are forced to zero so the
// downstream stations never see a false dependency.
module issue_ctrl_decoder
    import issue_ctrl_pkg::*;
(
    input  inst_t inst_i,
    output dec_t  dec_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7b;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign f7b = inst_i[30];

    always_comb begin
        dec_o          = '0;
        dec_o.op       = OP_NOP;
        dec_o.rd       = inst_i[11:7];
        dec_o.rs1      = inst_i[19:15];
        dec_o.rs2      = inst_i[24:20];
        dec_o.imm      = {{20{inst_i[31]}}, inst_i[31:20]};
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                dec_o.op  = (opc == OPC_LUI) ? OP_LUI : OP_AUIPC;
                dec_o.imm = {inst_i[31:12], 12'b0};
                dec_o.rs1 = '0;
                dec_o.rs2 = '0;
            end
            OPC_JAL: begin
                dec_o.op    = OP_JAL;
                dec_o.imm   = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                               inst_i[30:21], 1'b0};
                dec_o.rs1   = '0;
                dec_o.rs2   = '0;
                dec_o.is_br = 1'b1;
            end
            OPC_JALR: begin
                dec_o.op    = OP_JALR;
                dec_o.rs2   = '0;
                dec_o.is_br = 1'b1;
            end
            OPC_BRANCH: begin
                dec_o.imm   = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                               inst_i[11:8], 1'b0};
                dec_o.rd    = '0;
                dec_o.is_br = 1'b1;
                case (f3)
                    3'd0:    dec_o.op = OP_BEQ;
                    3'd1:    dec_o.op = OP_BNE;
                    3'd4:    dec_o.op = OP_BLT;
                    3'd5:    dec_o.op = OP_BGE;
                    3'd6:    dec_o.op = OP_BLTU;
                    3'd7:    dec_o.op = OP_BGEU;
                    default: dec_o.op = OP_NOP;
                endcase
            end
            OPC_LOAD: begin
                dec_o.rs2   = '0;
                dec_o.is_ls = 1'b1;
                case (f3)
                    3'd0:    dec_o.op = OP_LB;
                    3'd1:    dec_o.op = OP_LH;
                    3'd2:    dec_o.op = OP_LW;
                    3'd4:    dec_o.op = OP_LBU;
                    3'd5:    dec_o.op = OP_LHU;
                    default: dec_o.op = OP_NOP;
                endcase
            end
            OPC_STORE: begin
                dec_o.imm      = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                dec_o.rd       = '0;
                dec_o.is_ls    = 1'b1;
                dec_o.is_store = 1'b1;
                case (f3)
                    3'd0:    dec_o.op = OP_SB;
                    3'd1:    dec_o.op = OP_SH;
                    3'd2:    dec_o.op = OP_SW;
                    default: dec_o.op = OP_NOP;
                endcase
            end
            OPC_OPIMM: begin
                dec_o.rs2 = '0;
                case (f3)
                    3'd0:    dec_o.op = OP_ADDI;
                    3'd1:    dec_o.op = OP_SLLI;
                    3'd2:    dec_o.op = OP_SLTI;
                    3'd3:    dec_o.op = OP_SLTIU;
                    3'd4:    dec_o.op = OP_XORI;
                    3'd5:    dec_o.op = f7b ? OP_SRAI : OP_SRLI;
                    3'd6:    dec_o.op = OP_ORI;
                    default: dec_o.op = OP_ANDI;
                endcase
            end
            OPC_OP: begin
                dec_o.imm = '0;
                case (f3)
                    3'd0:    dec_o.op = f7b ? OP_SUB : OP_ADD;
                    3'd1:    dec_o.op = OP_SLL;
                    3'd2:    dec_o.op = OP_SLT;
                    3'd3:    dec_o.op = OP_SLTU;
                    3'd4:    dec_o.op = OP_XOR;
                    3'd5:    dec_o.op = f7b ? OP_SRA : OP_SRL;
                    3'd6:    dec_o.op = OP_OR;
                    default: dec_o.op = OP_AND;
                endcase
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: buffers fetched instructions in a small FIFO, decodes
// the head and dispatches it through one registered slot to either the
// reservation station (RS) or the load/store buffer (LSB).
//   clk_in, rst_in (async, active-low), rdy_in (global enable)
//   inst_valid_in/inst_ready_out, inst_in, pc_in : fetch side
//   flush_in : mispredict flush, br_done_in : branch/jump resolved
//   rs_valid_out/rs_ready_in, lsb_valid_out/lsb_ready_in : dispatch side
//   op_out, rd_out, rs1_out, rs2_out, imm_out, pc_out, is_store_out : payload
//   illegal_out : one-cycle pulse when a head with unknown opcode is dropped
//   dbg_state_out, dbg_count_out : FSM state and queue occupancy
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high (and rdy_in is high). A producer holding valid keeps valid and
// payload stable until that edge; ready may change freely.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         inst_valid_in,
    input  inst_t                        inst_in,
    input  logic [31:0]                  pc_in,
    output logic                         inst_ready_out,
    input  logic                         flush_in,
    input  logic                         br_done_in,
    output logic                         rs_valid_out,
    input  logic                         rs_ready_in,
    output logic                         lsb_valid_out,
    input  logic                         lsb_ready_in,
    output op_e                          op_out,
    output reg_id_t                      rd_out,
    output reg_id_t                      rs1_out,
    output reg_id_t                      rs2_out,
    output imm_t                         imm_out,
    output logic [31:0]                  pc_out,
    output logic                         is_store_out,
    output logic                         illegal_out,
    output st_e                          dbg_state_out,
    output logic [$clog2(QUEUE_DEPTH):0] dbg_count_out
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

    // queue storage: no reset needed, occupancy is tracked by count_q
    inst_t       mem_inst [QUEUE_DEPTH];
    logic [31:0] mem_pc   [QUEUE_DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic        slot_valid_q, slot_valid_d;
    logic        slot_lsb_q, slot_lsb_d;
    op_e         op_q, op_d;
    reg_id_t     rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    imm_t        imm_q, imm_d;
    logic [31:0] spc_q, spc_d;
    logic        is_store_q, is_store_d;
    logic        illegal_q, illegal_d;

    st_e  state_q, state_d;
    logic run_ok;

    dec_t head_dec;
    logic enq, take, load, drop, slot_fire, br_loaded, q_empty;

    issue_ctrl_decoder u_dec (
        .inst_i (mem_inst[head_q]),
        .dec_o  (head_dec)
    );

    // ---------------------------------------------------------------
    // Control. rdy_in low freezes everything, including a pending flush;
    // with rdy_in high, flush overrides every other update.
    // ---------------------------------------------------------------
    assign q_empty        = (count_q == '0);
    assign inst_ready_out = (count_q != FULL_CNT) && !flush_in && rdy_in;
    assign enq            = inst_valid_in && inst_ready_out;
    assign slot_fire      = rdy_in && !flush_in && slot_valid_q &&
                            (slot_lsb_q ? lsb_ready_in : rs_ready_in);
    // the head leaves the queue either into the slot or as a dropped illegal
    assign take           = rdy_in && !flush_in && !q_empty && run_ok &&
                            (!slot_valid_q || slot_fire);
    assign load           = take && !head_dec.illegal;
    assign drop           = take && head_dec.illegal;
    assign br_loaded      = load && head_dec.is_br;

    // ---------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (flush_in) begin
                state_d = ST_RUN;
            end else begin
                case (state_q)
                    ST_RUN:     if (br_loaded)  state_d = ST_WAIT_BR;
                    ST_WAIT_BR: if (br_done_in) state_d = ST_RUN;
                    default:    state_d = ST_RUN;
                endcase
            end
        end
    end

    always_comb begin
        run_ok = (state_q == ST_RUN);
    end

    // ---------------------------------------------------------------
    // Queue pointers and dispatch slot
    // ---------------------------------------------------------------
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        slot_valid_d = slot_valid_q;
        slot_lsb_d   = slot_lsb_q;
        op_d         = op_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        spc_d        = spc_q;
        is_store_d   = is_store_q;
        illegal_d    = illegal_q;
        if (rdy_in) begin
            illegal_d = drop;
            if (flush_in) begin
                head_d       = '0;
                tail_d       = '0;
                count_d      = '0;
                slot_valid_d = 1'b0;
            end else begin
                if (enq)  tail_d = tail_q + PW'(1);
                if (take) head_d = head_q + PW'(1);
                count_d = count_q + CW'(enq) - CW'(take);
                if (slot_fire) slot_valid_d = 1'b0;
                if (load) begin
                    slot_valid_d = 1'b1;
                    slot_lsb_d   = head_dec.is_ls;
                    op_d         = head_dec.op;
                    rd_d         = head_dec.rd;
                    rs1_d        = head_dec.rs1;
                    rs2_d        = head_dec.rs2;
                    imm_d        = head_dec.imm;
                    spc_d        = mem_pc[head_q];
                    is_store_d   = head_dec.is_store;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            slot_valid_q <= 1'b0;
            slot_lsb_q   <= 1'b0;
            op_q         <= OP_NOP;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            spc_q        <= '0;
            is_store_q   <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            slot_valid_q <= slot_valid_d;
            slot_lsb_q   <= slot_lsb_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            spc_q        <= spc_d;
            is_store_q   <= is_store_d;
            illegal_q    <= illegal_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq) begin
            mem_inst[tail_q] <= inst_in;
            mem_pc[tail_q]   <= pc_in;
        end
    end

    assign rs_valid_out  = slot_valid_q && !slot_lsb_q;
    assign lsb_valid_out = slot_valid_q && slot_lsb_q;
    assign op_out        = op_q;
    assign rd_out        = rd_q;
    assign rs1_out       = rs1_q;
    assign rs2_out       = rs2_q;
    assign imm_out       = imm_q;
    assign pc_out        = spc_q;
    assign is_store_out  = is_store_q;
    assign illegal_out   = illegal_q;
    assign dbg_state_out = state_q;
    assign dbg_count_out = count_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl. Inputs change 1 ns after a rising edge and
// outputs are checked there too, well away from the next edge.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD  = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_BEQ  = 32'h0020_8463; // beq  x1,x2,+8
  localparam logic [31:0] I_SW   = 32'h0020_A223; // sw   x2,4(x1)
  localparam logic [31:0] I_LW   = 32'h0080_A283; // lw   x5,8(x1)
  localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rdy_in = 1'b1, inst_valid_in = 1'b0, flush_in = 1'b0, br_done_in = 1'b0;
  logic        rs_ready_in = 1'b0, lsb_ready_in = 1'b0;
  logic [31:0] inst_in = '0, pc_in = '0;
  logic        inst_ready_out, rs_valid_out, lsb_valid_out, is_store_out, illegal_out;
  op_e         op_out;
  reg_id_t     rd_out, rs1_out, rs2_out;
  imm_t        imm_out;
  logic [31:0] pc_out;
  st_e         dbg_state_out;
  logic [2:0]  dbg_count_out;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  issue_ctrl #(.QUEUE_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .inst_valid_in(inst_valid_in), .inst_in(inst_in), .pc_in(pc_in),
    .inst_ready_out(inst_ready_out), .flush_in(flush_in), .br_done_in(br_done_in),
    .rs_valid_out(rs_valid_out), .rs_ready_in(rs_ready_in),
    .lsb_valid_out(lsb_valid_out), .lsb_ready_in(lsb_ready_in),
    .op_out(op_out), .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .imm_out(imm_out), .pc_out(pc_out), .is_store_out(is_store_out),
    .illegal_out(illegal_out), .dbg_state_out(dbg_state_out),
    .dbg_count_out(dbg_count_out)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic offer(input logic [31:0] w, input logic [31:0] pc);
    inst_valid_in = 1'b1;
    inst_in = w;
    pc_in = pc;
  endtask

  task automatic idle_inputs();
    inst_valid_in = 1'b0;
    flush_in = 1'b0;
    br_done_in = 1'b0;
    rs_ready_in = 1'b0;
    lsb_ready_in = 1'b0;
    rdy_in = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_in = 1'b0;
    #3;
    checks++;
    if (rs_valid_out !== 1'b0 || lsb_valid_out !== 1'b0 || illegal_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids: rs=%b lsb=%b ill=%b expected 0 0 0", rs_valid_out, lsb_valid_out, illegal_out);
    end
    checks++;
    if (dbg_count_out !== 3'd0 || dbg_state_out !== ST_RUN || op_out !== OP_NOP || imm_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: count=%0d state=%0d op=%0d imm=%h expected 0 RUN NOP 0", dbg_count_out, dbg_state_out, op_out, imm_out);
    end
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    rs_ready_in = 1'b1;
    offer(I_ADDI, 32'h100);
    checks++;
    if (inst_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL addi_ready: got %b expected 1", inst_ready_out);
    end
    tick();
    inst_valid_in = 1'b0;
    checks++;
    if (rs_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL addi_not_early: rs_valid=%b expected 0", rs_valid_out);
    end
    tick();
    checks++;
    if (rs_valid_out !== 1'b1 || lsb_valid_out !== 1'b0 || op_out !== OP_ADDI || rd_out !== 5'd1 ||
        rs1_out !== 5'd0 || imm_out !== 32'd5 || pc_out !== 32'h100) begin
      failures++;
      $display("FAIL addi_dispatch: rs=%b lsb=%b op=%0d rd=%0d rs1=%0d imm=%0d pc=%h expected 1 0 ADDI 1 0 5 100",
               rs_valid_out, lsb_valid_out, op_out, rd_out, rs1_out, imm_out, pc_out);
    end
    tick();
    checks++;
    if (rs_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL addi_drained: rs_valid=%b expected 0", rs_valid_out);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int got;
    rs_ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      offer((32'(i) << 20) | (32'(i) << 7) | 32'h13, 32'(i * 4));
      exp_q.push_back(5'(i));
      checks++;
      if (inst_ready_out !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d: got %b expected 1", i, inst_ready_out);
      end
      tick();
    end
    inst_valid_in = 1'b0;
    checks++;
    if (inst_ready_out !== 1'b0 || dbg_count_out !== 3'd4 || rs_valid_out !== 1'b1 || rd_out !== 5'd1) begin
      failures++;
      $display("FAIL b2b_full: ready=%b count=%0d rs=%b rd=%0d expected 0 4 1 1", inst_ready_out, dbg_count_out, rs_valid_out, rd_out);
    end
    repeat (3) tick();
    checks++;
    if (rs_valid_out !== 1'b1 || rd_out !== 5'd1 || imm_out !== 32'd1 || pc_out !== 32'd4) begin
      failures++;
      $display("FAIL b2b_stable: rs=%b rd=%0d imm=%0d pc=%0d expected 1 1 1 4", rs_valid_out, rd_out, imm_out, pc_out);
    end
    // dequeue happening this cycle must not open the door while full
    offer(I_ADD, 32'h0);
    rs_ready_in = 1'b1;
    #1;
    checks++;
    if (inst_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_bypass: ready=%b expected 0", inst_ready_out);
    end
    inst_valid_in = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (rs_valid_out === 1'b1) begin
        logic [4:0] e;
        e = exp_q.pop_front();
        got++;
        checks++;
        if (rd_out !== e) begin
          failures++;
          $display("FAIL b2b_order: rd=%0d expected %0d", rd_out, e);
        end
      end
      tick();
    end
    checks++;
    if (got !== 5 || rs_valid_out !== 1'b0 || dbg_count_out !== 3'd0) begin
      failures++;
      $display("FAIL b2b_drain: dispatched=%0d rs=%b count=%0d expected 5 0 0", got, rs_valid_out, dbg_count_out);
    end
    exp_q.delete();
    idle_inputs();
    tick();
  endtask

  task automatic test_branch_wait();
    rs_ready_in = 1'b1;
    offer(I_BEQ, 32'h200);
    tick();
    offer(I_ADD, 32'h204);
    tick();
    inst_valid_in = 1'b0;
    checks++;
    if (rs_valid_out !== 1'b1 || op_out !== OP_BEQ || imm_out !== 32'd8 || rd_out !== 5'd0 ||
        rs2_out !== 5'd2 || dbg_state_out !== ST_WAIT_BR) begin
      failures++;
      $display("FAIL br_dispatch: rs=%b op=%0d imm=%0d rd=%0d rs2=%0d state=%0d expected 1 BEQ 8 0 2 WAIT_BR",
               rs_valid_out, op_out, imm_out, rd_out, rs2_out, dbg_state_out);
    end
    repeat (3) tick();
    checks++;
    if (rs_valid_out !== 1'b0 || dbg_count_out !== 3'd1 || dbg_state_out !== ST_WAIT_BR) begin
      failures++;
      $display("FAIL br_hold: rs=%b count=%0d state=%0d expected 0 1 WAIT_BR", rs_valid_out, dbg_count_out, dbg_state_out);
    end
    br_done_in = 1'b1;
    tick();
    br_done_in = 1'b0;
    checks++;
    if (dbg_state_out !== ST_RUN || rs_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL br_resume: state=%0d rs=%b expected RUN 0", dbg_state_out, rs_valid_out);
    end
    tick();
    checks++;
    if (rs_valid_out !== 1'b1 || op_out !== OP_ADD || rd_out !== 5'd3 || rs1_out !== 5'd1 || rs2_out !== 5'd2) begin
      failures++;
      $display("FAIL br_add: rs=%b op=%0d rd=%0d rs1=%0d rs2=%0d expected 1 ADD 3 1 2", rs_valid_out, op_out, rd_out, rs1_out, rs2_out);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    offer(I_SW, 32'h300);
    tick();
    offer(I_ADDI, 32'h304);
    tick();
    inst_valid_in = 1'b0;
    checks++;
    if (lsb_valid_out !== 1'b1 || rs_valid_out !== 1'b0 || op_out !== OP_SW || is_store_out !== 1'b1 ||
        imm_out !== 32'd4 || dbg_count_out !== 3'd1) begin
      failures++;
      $display("FAIL flush_setup: lsb=%b rs=%b op=%0d st=%b imm=%0d count=%0d expected 1 0 SW 1 4 1",
               lsb_valid_out, rs_valid_out, op_out, is_store_out, imm_out, dbg_count_out);
    end
    flush_in = 1'b1;
    offer(I_LW, 32'h308);
    #1;
    checks++;
    if (inst_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: ready=%b expected 0", inst_ready_out);
    end
    tick();
    flush_in = 1'b0;
    inst_valid_in = 1'b0;
    checks++;
    if (lsb_valid_out !== 1'b0 || dbg_count_out !== 3'd0 || dbg_state_out !== ST_RUN || illegal_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: lsb=%b count=%0d state=%0d ill=%b expected 0 0 RUN 0", lsb_valid_out, dbg_count_out, dbg_state_out, illegal_out);
    end
    repeat (2) tick();
    checks++;
    if (lsb_valid_out !== 1'b0 || rs_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard: lsb=%b rs=%b expected 0 0", lsb_valid_out, rs_valid_out);
    end
    idle_inputs();
  endtask

  task automatic test_illegal();
    lsb_ready_in = 1'b1;
    offer(I_BAD, 32'h400);
    tick();
    offer(I_LW, 32'h404);
    tick();
    inst_valid_in = 1'b0;
    checks++;
    if (illegal_out !== 1'b1 || rs_valid_out !== 1'b0 || lsb_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL ill_pulse: ill=%b rs=%b lsb=%b expected 1 0 0", illegal_out, rs_valid_out, lsb_valid_out);
    end
    tick();
    checks++;
    if (illegal_out !== 1'b0 || lsb_valid_out !== 1'b1 || is_store_out !== 1'b0 || op_out !== OP_LW ||
        rd_out !== 5'd5 || imm_out !== 32'd8 || pc_out !== 32'h404) begin
      failures++;
      $display("FAIL ill_lw: ill=%b lsb=%b st=%b op=%0d rd=%0d imm=%0d pc=%h expected 0 1 0 LW 5 8 404",
               illegal_out, lsb_valid_out, is_store_out, op_out, rd_out, imm_out, pc_out);
    end
    tick();
    checks++;
    if (lsb_valid_out !== 1'b0 || illegal_out !== 1'b0) begin
      failures++;
      $display("FAIL ill_done: lsb=%b ill=%b expected 0 0", lsb_valid_out, illegal_out);
    end
    idle_inputs();
  endtask

  task automatic test_freeze();
    rdy_in = 1'b0;
    offer(I_ADDI, 32'h500);
    #1;
    checks++;
    if (inst_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL freeze_ready: ready=%b expected 0", inst_ready_out);
    end
    repeat (2) tick();
    checks++;
    if (dbg_count_out !== 3'd0 || rs_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL freeze_hold: count=%0d rs=%b expected 0 0", dbg_count_out, rs_valid_out);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    rs_ready_in = 1'b0;
    offer(I_ADDI, 32'h600);
    tick();
    inst_valid_in = 1'b0;
    tick();
    checks++;
    if (rs_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup: rs=%b expected 1", rs_valid_out);
    end
    rs_ready_in = 1'b1;
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (rs_valid_out !== 1'b0 || lsb_valid_out !== 1'b0 || dbg_count_out !== 3'd0 || op_out !== OP_NOP || rd_out !== 5'd0) begin
      failures++;
      $display("FAIL arst_async: rs=%b lsb=%b count=%0d op=%0d rd=%0d expected 0 0 0 NOP 0", rs_valid_out, lsb_valid_out, dbg_count_out, op_out, rd_out);
    end
    rst_in = 1'b1;
    offer(I_ADDI, 32'h700);
    tick();
    inst_valid_in = 1'b0;
    checks++;
    if (rs_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL arst_latency: rs=%b one edge after release expected 0", rs_valid_out);
    end
    tick();
    checks++;
    if (rs_valid_out !== 1'b1 || pc_out !== 32'h700) begin
      failures++;
      $display("FAIL arst_first: rs=%b pc=%h expected 1 700", rs_valid_out, pc_out);
    end
    idle_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #1;
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_wait();
    test_flush();
    test_illegal();
    test_freeze();
    test_async_reset();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
